regex_stream_ctrl: RTL

//  Sequences one binary-alphabet regex matcher (the "regex" wrapper: clk, reset, token-in i, symbol i_c, match o).

---
 rtl/regex_stream_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/regex_stream_ctrl.sv
// Purpose : feeds a symbol stream into a binary-alphabet regex matcher back to back and reports match ends.
// Latency : a match shows on m_valid MATCH_LAT+1 clocks after its last symbol is popped from the FIFO.
// Backpressure: s_ready drops when the FIFO is full or the stream's last symbol is in; events drop when m_valid is held.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   start, anchored            begin a stream (IDLE only); anchored selects a token on the first symbol only
//   s_valid/s_ready/s_data/s_last   input symbol stream
//   re_reset/re_i/re_c/re_o    matcher reset, start token, symbol, match result
//   m_valid/m_ready/m_pos      one-entry match event port (0-based position of the match's last symbol)
//   match_cnt                  matches seen this stream, including dropped ones
//   busy, done                 state != IDLE; one-cycle end-of-stream pulse
//   err_underrun, err_overflow sticky stream errors, cleared on start
module regex_stream_ctrl #(
  parameter int DEPTH      = 16,
  parameter int POS_W      = 16,
  parameter int MATCH_LAT  = 1,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             anchored,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_data,
  input  logic             s_last,
  output logic             re_reset,
  output logic             re_i,
  output logic             re_c,
  input  logic             re_o,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [POS_W-1:0] m_pos,
  output logic [POS_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             err_underrun,
  output logic             err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int DW = $clog2(MATCH_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state;

  // FIFO entry: {last, data}
  logic [1:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fcnt;
  logic [AW:0]      fcnt_nxt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_dat;
  logic             head_last;

  logic             anch_q;
  logic             last_taken;
  logic [POS_W-1:0] pos;
  logic [CW-1:0]    clr_cnt;
  logic [DW-1:0]    drn_cnt;

  // Stage 0 lines up with the symbol on re_c; stage MATCH_LAT lines up with its result on re_o.
  logic [MATCH_LAT:0] vld_pipe;
  logic [POS_W-1:0]   pos_pipe [MATCH_LAT+1];
  logic               hit;

  assign full      = (fcnt == (AW+1)'(DEPTH));
  assign empty     = (fcnt == '0);
  // Ready ignores a same-cycle pop: a full FIFO stalls the feeder for one cycle rather than
  // making s_ready depend on the pop decision.
  assign s_ready   = ((state == ST_FILL) || (state == ST_RUN)) && !full && !last_taken;
  assign push      = s_valid && s_ready;
  assign pop       = (state == ST_RUN) && !empty;
  assign fcnt_nxt  = fcnt + (AW+1)'(push) - (AW+1)'(pop);
  assign head_dat  = mem[rd_ptr][0];
  assign head_last = mem[rd_ptr][1];
  assign hit       = vld_pipe[MATCH_LAT] && re_o;

  assign re_reset  = reset || (state == ST_CLEAR);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_last, s_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fcnt         <= '0;
      anch_q       <= 1'b0;
      last_taken   <= 1'b0;
      pos          <= '0;
      clr_cnt      <= '0;
      drn_cnt      <= '0;
      re_i         <= 1'b0;
      re_c         <= 1'b0;
      vld_pipe     <= '0;
      for (int k = 0; k <= MATCH_LAT; k++) begin
        pos_pipe[k] <= '0;
      end
      m_valid      <= 1'b0;
      m_pos        <= '0;
      match_cnt    <= '0;
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      re_i        <= 1'b0;
      re_c        <= 1'b0;
      vld_pipe[0] <= 1'b0;
      for (int k = 1; k <= MATCH_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        pos_pipe[k] <= pos_pipe[k-1];
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fcnt <= fcnt_nxt;
      if (push && s_last) begin
        last_taken <= 1'b1;
      end

      // One-entry event register: a new match only lands if the slot is free or being emptied.
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (hit) begin
        match_cnt <= match_cnt + 1'b1;
        if (!m_valid || m_ready) begin
          m_valid <= 1'b1;
          m_pos   <= pos_pipe[MATCH_LAT];
        end else begin
          err_overflow <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_CLEAR;
            anch_q       <= anchored;
            clr_cnt      <= '0;
            pos          <= '0;
            last_taken   <= 1'b0;
            match_cnt    <= '0;
            err_underrun <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if ((push && s_last) || (fcnt_nxt == (AW+1)'(DEPTH))) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pop) begin
            re_c        <= head_dat;
            re_i        <= anch_q ? (pos == '0) : 1'b1;
            vld_pipe[0] <= 1'b1;
            pos_pipe[0] <= pos;
            pos         <= pos + 1'b1;
            if (head_last) begin
              state   <= ST_DRAIN;
              drn_cnt <= '0;
            end
          end else begin
            // The matcher cannot stall: an idle slot breaks any partial match in flight.
            err_underrun <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle still carries the last symbol on re_c; its result is
          // sampled MATCH_LAT cycles later, at the end of the final DRAIN cycle.
          if (drn_cnt == DW'(MATCH_LAT)) begin
            state <= ST_DONE;
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
